// File: rtl/store_display_pacer.sv
// Captures 16-bit stores to one MMIO address into a small FIFO and replays them
// on the display one at a time, each held for a fixed dwell so a human can read it.
module store_display_pacer #(
   parameter logic [31:0] MATCH_ADDR   = 32'h0000_1000,
   parameter int          DEPTH        = 8,
   parameter int          DWELL_CYCLES = 100_000_000
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     wr_en_i,
   input  logic [31:0]              wr_addr_i,
   input  logic [31:0]              wr_data_i,
   input  logic                     skip_i,
   input  logic                     clr_ovf_i,
   output logic [15:0]              disp_value_o,
   output logic                     disp_valid_o,
   output logic [$clog2(DEPTH):0]   fifo_count_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DWELL_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t          state_q, state_d;
   logic [15:0]     mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [AW:0]     count_q, count_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     value_q, value_d;
   logic            ovf_q, ovf_d;
   logic            push_req, push, pop, drop, nonempty, full, dwell_end;
   logic            unused_hi;

   assign unused_hi = ^wr_data_i[31:16];
   assign push_req  = wr_en_i && (wr_addr_i == MATCH_ADDR);
   assign nonempty  = (count_q != '0);
   assign full      = (count_q == FULL);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      value_d   = value_q;
      pop       = 1'b0;
      dwell_end = 1'b0;
      case (state_q)
         IDLE: begin
            if (nonempty) begin
               pop     = 1'b1;
               value_d = mem_q[rptr_q];
               cnt_d   = '0;
               state_d = SHOW;
            end
         end
         SHOW: begin
            dwell_end = skip_i || (cnt_q == LAST);
            if (dwell_end) begin
               cnt_d = '0;
               if (nonempty) begin
                  pop     = 1'b1;
                  value_d = mem_q[rptr_q];
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A pop on the same edge frees the slot, so a push into a full FIFO survives.
      push = push_req && (!full || pop);
      drop = push_req && full && !pop;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      ovf_d = ovf_q;
      if (drop)
         ovf_d = 1'b1;
      else if (clr_ovf_i)
         ovf_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         cnt_q   <= '0;
         value_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         cnt_q   <= cnt_d;
         value_q <= value_d;
         ovf_q   <= ovf_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   // Storage needs no reset: the pointers and count decide what is valid.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= wr_data_i[15:0];
   end

   assign disp_value_o = value_q;
   assign disp_valid_o = (state_q == SHOW);
   assign fifo_count_o = count_q;
   assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_store_display_pacer.sv
// Directed bench for store_display_pacer (DEPTH=4, DWELL_CYCLES=4); a monitor
// checks every displayed value and its dwell length against a scoreboard queue.
module tb_store_display_pacer;

   typedef struct {
      logic [15:0] v;
      int          len;   // -1: dwell is cut short, length not checked
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        skip = 1'b0;
   logic        clr_ovf = 1'b0;
   logic [15:0] disp_value;
   logic        disp_valid;
   logic [2:0]  fifo_count;
   logic        overflow;

   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   store_display_pacer #(
      .MATCH_ADDR   (32'h0000_1000),
      .DEPTH        (4),
      .DWELL_CYCLES (4)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .skip_i       (skip),
      .clr_ovf_i    (clr_ovf),
      .disp_value_o (disp_value),
      .disp_valid_o (disp_valid),
      .fifo_count_o (fifo_count),
      .overflow_o   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic nedge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0;
      skip = 1'b0;
      clr_ovf = 1'b0;
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      wr_en = 1'b1;
      wr_addr = addr;
      wr_data = data;
   endtask

   task automatic expect_show(input logic [15:0] v, input int len);
      exp_t e;
      e.v = v;
      e.len = len;
      exp_q.push_back(e);
   endtask

   // Monitor: a new dwell starts when valid rises or the shown value changes.
   logic        prev_valid = 1'b0;
   logic [15:0] prev_value = '0;
   logic        in_seg = 1'b0;
   int          seg_len = 0;
   int          seg_exp_len = 0;

   always @(negedge clk) begin
      logic new_start;
      exp_t e;
      if (!rst_n) begin
         in_seg = 1'b0;
      end else begin
         new_start = disp_valid && (!prev_valid || disp_value != prev_value);
         if (in_seg && (!disp_valid || new_start) && seg_exp_len >= 0)
            check($sformatf("dwell_len_%h", prev_value), seg_len, seg_exp_len);
         if (new_start) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_display: got %h, expected nothing", disp_value);
               seg_exp_len = -1;
            end else begin
               e = exp_q.pop_front();
               check("display_value", disp_value, e.v);
               seg_exp_len = e.len;
            end
            seg_len = 1;
            in_seg = 1'b1;
         end else if (disp_valid) begin
            seg_len++;
         end
         if (!disp_valid) in_seg = 1'b0;
      end
      prev_valid = disp_valid;
      prev_value = disp_value;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int run;

      // 1: reset state, then quiet after release
      repeat (2) nedge();
      check("rst_disp_value", disp_value, 16'h0000);
      check("rst_disp_valid", disp_valid, 1'b0);
      check("rst_fifo_count", fifo_count, 3'd0);
      check("rst_overflow", overflow, 1'b0);
      rst_n = 1'b1;
      repeat (3) nedge();
      check("post_rst_valid", disp_valid, 1'b0);
      check("post_rst_value", disp_value, 16'h0000);

      // 2: single store, latency and dwell
      store(32'h0000_1000, 32'h0000_ABCD);
      expect_show(16'hABCD, 4);
      nedge(); idle_inputs();
      check("single_count_N", fifo_count, 3'd1);
      nedge();
      check("single_valid_N1", disp_valid, 1'b1);
      check("single_value_N1", disp_value, 16'hABCD);
      check("single_count_N1", fifo_count, 3'd0);
      repeat (3) nedge();
      check("single_valid_N4", disp_valid, 1'b1);
      nedge();
      check("single_valid_N5", disp_valid, 1'b0);
      check("single_hold_N5", disp_value, 16'hABCD);

      // 3: address filter
      store(32'h0000_1004, 32'h0000_1234);
      nedge();
      store(32'h0001_1000, 32'h0000_5678);
      nedge(); idle_inputs();
      check("filter_count", fifo_count, 3'd0);
      repeat (3) nedge();
      check("filter_valid", disp_valid, 1'b0);
      check("filter_value", disp_value, 16'hABCD);

      // 4: burst; dwell of 1 ends on store 6 so 6 fits, 7 and 8 are dropped
      for (int v = 1; v <= 6; v++) expect_show(16'(v), 4);
      for (int i = 1; i <= 9; i++) begin
         if (i == 2) check("burst_count_e1", fifo_count, 3'd1);
         if (i == 7) begin
            check("burst_count_full_pop", fifo_count, 3'd4);
            check("burst_ovf_full_pop", overflow, 1'b0);
         end
         if (i == 8) begin
            check("burst_count_drop", fifo_count, 3'd4);
            check("burst_ovf_drop", overflow, 1'b1);
         end
         if (i == 9) check("burst_ovf_set_wins", overflow, 1'b1);
         idle_inputs();
         if (i <= 8) store(32'h0000_1000, i);
         if (i >= 8) clr_ovf = 1'b1;
         nedge();
      end
      idle_inputs();
      check("burst_ovf_cleared", overflow, 1'b0);
      run = 8;
      for (int k = 0; k < 100; k++) begin
         nedge();
         if (!disp_valid) break;
         run++;
      end
      check("burst_gapless_cycles", run, 24);

      // 5: skip in the 2nd dwell cycle of 1111
      expect_show(16'h1111, 2);
      expect_show(16'h2222, 4);
      store(32'h0000_1000, 32'h0000_1111);
      nedge();
      store(32'h0000_1000, 32'h0000_2222);
      nedge(); idle_inputs();
      nedge();
      skip = 1'b1;
      nedge(); idle_inputs();
      check("skip_value", disp_value, 16'h2222);
      check("skip_valid", disp_valid, 1'b1);
      repeat (6) nedge();
      check("skip_idle", disp_valid, 1'b0);

      // 6: asynchronous reset mid-dwell discards everything
      expect_show(16'h00A1, -1);
      store(32'h0000_1000, 32'h0000_00A1);
      nedge();
      store(32'h0000_1000, 32'h0000_00A2);
      nedge();
      store(32'h0000_1000, 32'h0000_00A3);
      nedge(); idle_inputs();
      check("midreset_showing", disp_valid, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset_count", fifo_count, 3'd0);
      check("midreset_value", disp_value, 16'h0000);
      check("midreset_valid", disp_valid, 1'b0);
      exp_q.delete();
      repeat (2) nedge();
      rst_n = 1'b1;
      repeat (20) nedge();
      check("after_reset_valid", disp_valid, 1'b0);
      check("after_reset_value", disp_value, 16'h0000);
      check("after_reset_count", fifo_count, 3'd0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
